sram_mbist_ctrl: RTL and testbench

- March C- memory BIST engine that drives the BIST-side port (BIST, CEBM, WEBM, AM, DM, BWEBM) of a single-port 1024x32 SRAM macro and checks its Q output.
- Sits beside each SRAM instance. The top level pulses start after reset and reads back pass/fail before functional traffic uses the macro.
- Runs the whole march autonomously. It reports busy, done and a sticky fail flag.

---
 rtl/mbist_pkg.sv | 36 +++
 rtl/mbist_addr_gen.sv | 48 ++++
 rtl/sram_mbist_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_sram_mbist_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mbist_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : mbist_pkg
//  Purpose : Shared types and March C- element tables for sram_mbist_ctrl.
//            Bit i of every table describes march element i:
//              E0 up(w0)  E1 up(r0,w1)  E2 up(r1,w0)
//              E3 dn(r0,w1)  E4 dn(r1,w0)  E5 up(r0)
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package mbist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int NUM_ELEM = 6;
  localparam int ELEM_W   = 3;

  // 1 = element walks addresses downward
  localparam logic [NUM_ELEM-1:0] ELEM_DOWN     = 6'b011000;
  // 1 = two ops per address (read then write), 0 = single op
  localparam logic [NUM_ELEM-1:0] ELEM_TWO_OP   = 6'b011110;
  // For single-op elements: 1 = that op is a write
  localparam logic [NUM_ELEM-1:0] ELEM_FIRST_WR = 6'b000001;
  // Expected read value: 1 = all ones, 0 = all zeros
  localparam logic [NUM_ELEM-1:0] ELEM_RD_POL   = 6'b010100;
  // Write data: 1 = all ones, 0 = all zeros
  localparam logic [NUM_ELEM-1:0] ELEM_WR_POL   = 6'b001010;

endpackage
`default_nettype wire

// File: rtl/mbist_addr_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : mbist_addr_gen
//  Purpose : Up/down address counter for the march engine, with a load of
//            the element start address and a terminal-count flag.
//  Ports   : clk, rst_n     clock, async active-low reset
//            i_load         load start address (takes priority over step)
//            i_load_down    start address select: 1 = NUM_WORD-1, 0 = 0
//            i_step         advance one address in direction i_down
//            i_down         current direction (1 = decrement)
//            o_addr         current address
//            o_last         current address is the terminal one for i_down
//  Rev     : 1.0  initial release
// ============================================================================
module mbist_addr_gen #(
  parameter int NUM_WORD = 1024,
  parameter int ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_load_down,
  input  logic              i_step,
  input  logic              i_down,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORD - 1);

  logic [ADDR_W-1:0] r_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
    end else if (i_load) begin
      r_addr <= i_load_down ? LAST_ADDR : '0;
    end else if (i_step) begin
      r_addr <= i_down ? (r_addr - 1'b1) : (r_addr + 1'b1);
    end
  end

  assign o_addr = r_addr;
  assign o_last = i_down ? (r_addr == '0) : (r_addr == LAST_ADDR);

endmodule
`default_nettype wire

// File: rtl/sram_mbist_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : sram_mbist_ctrl
//  Purpose : March C- BIST engine for a single-port SRAM macro. Drives the
//            BIST-side port, checks Q one cycle after each read and reports
//            busy / sticky done / sticky fail.
//  Ports   : clk, rst_n     clock, async active-low reset
//            start          one-cycle launch pulse (honoured in IDLE/DONE)
//            Q              SRAM read data
//            BIST,CEBM,WEBM,AM,DM,BWEBM  SRAM BIST port (active-low enables)
//            bist_busy      test in progress (RUN/DRAIN)
//            bist_done      sticky, test finished
//            bist_fail      sticky, any miscompare
//  Option  : MBIST_DIAG_EN adds fail_addr / fail_elem / fail_bits, capturing
//            the first miscompare until the next start or reset.
//  Rev     : 1.0  initial release
// ============================================================================
module sram_mbist_ctrl
  import mbist_pkg::*;
#(
  parameter int NUM_WORD = 1024,
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] Q,
  output logic              BIST,
  output logic              CEBM,
  output logic              WEBM,
  output logic [ADDR_W-1:0] AM,
  output logic [DATA_W-1:0] DM,
  output logic [DATA_W-1:0] BWEBM,
  output logic              bist_busy,
  output logic              bist_done,
  output logic              bist_fail
`ifdef MBIST_DIAG_EN
  ,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [ELEM_W-1:0] fail_elem,
  output logic [DATA_W-1:0] fail_bits
`endif
);

  state_t              r_state, w_state_nxt;
  logic [ELEM_W-1:0]   r_elem, w_elem_nxt, w_elem_inc;
  logic                r_phase, w_phase_nxt;   // 0 = first op at address, 1 = second
  logic                w_load, w_load_down, w_step;
  logic [ADDR_W-1:0]   w_addr;
  logic                w_last;
  logic                w_run, w_is_write, w_addr_done, w_start_ok;

  logic                r_cmp_valid;
  logic [DATA_W-1:0]   r_cmp_exp;
  logic [DATA_W-1:0]   w_diff;
  logic                w_cmp_en, w_mis;
  logic                r_fail;

  assign w_run       = (r_state == ST_RUN);
  assign w_elem_inc  = r_elem + 3'd1;
  assign w_is_write  = ELEM_TWO_OP[r_elem] ? r_phase : ELEM_FIRST_WR[r_elem];
  assign w_addr_done = ~ELEM_TWO_OP[r_elem] | r_phase;
  assign w_start_ok  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  mbist_addr_gen #(
    .NUM_WORD (NUM_WORD),
    .ADDR_W   (ADDR_W)
  ) u_addr_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_load),
    .i_load_down (w_load_down),
    .i_step      (w_step),
    .i_down      (ELEM_DOWN[r_elem]),
    .o_addr      (w_addr),
    .o_last      (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_elem  <= '0;
      r_phase <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_elem  <= w_elem_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  // The terminal address of an element loads the next element's start
  // address directly, so consecutive elements run back to back.
  always_comb begin
    w_state_nxt = r_state;
    w_elem_nxt  = r_elem;
    w_phase_nxt = r_phase;
    w_load      = 1'b0;
    w_load_down = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_elem_nxt  = '0;
          w_phase_nxt = 1'b0;
          w_load      = 1'b1;
          w_load_down = ELEM_DOWN[0];
        end
      end
      ST_RUN: begin
        if (!w_addr_done) begin
          w_phase_nxt = 1'b1;
        end else begin
          w_phase_nxt = 1'b0;
          if (w_last) begin
            if (r_elem == ELEM_W'(NUM_ELEM - 1)) begin
              w_state_nxt = ST_DRAIN;
            end else begin
              w_elem_nxt  = w_elem_inc;
              w_load      = 1'b1;
              w_load_down = ELEM_DOWN[w_elem_inc];
            end
          end else begin
            w_step = 1'b1;
          end
        end
      end
      ST_DRAIN: w_state_nxt = ST_DONE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // SRAM port is decoded straight from state so an asynchronous reset puts
  // the pins in their idle values without waiting for a clock.
  assign BIST      = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign bist_busy = BIST;
  assign bist_done = (r_state == ST_DONE);
  assign CEBM      = ~w_run;
  assign WEBM      = ~(w_run & w_is_write);
  assign BWEBM     = (w_run & w_is_write) ? '0 : '1;
  assign DM        = (w_run & w_is_write & ELEM_WR_POL[r_elem]) ? '1 : '0;
  assign AM        = w_run ? w_addr : '0;

  // Compare stage: Q belongs to the read issued one cycle earlier.
  assign w_diff   = Q ^ r_cmp_exp;
  assign w_cmp_en = r_cmp_valid && (READ_LAT == 1);
  assign w_mis    = w_cmp_en && (|w_diff);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmp_valid <= 1'b0;
      r_cmp_exp   <= '0;
      r_fail      <= 1'b0;
    end else begin
      r_cmp_valid <= w_run & ~w_is_write;
      r_cmp_exp   <= ELEM_RD_POL[r_elem] ? '1 : '0;
      if (w_start_ok) begin
        r_fail <= 1'b0;
      end else if (w_mis) begin
        r_fail <= 1'b1;
      end
    end
  end

  assign bist_fail = r_fail;

`ifdef MBIST_DIAG_EN
  logic [ADDR_W-1:0] r_cmp_addr;
  logic [ELEM_W-1:0] r_cmp_elem;
  logic [ADDR_W-1:0] r_fail_addr;
  logic [ELEM_W-1:0] r_fail_elem;
  logic [DATA_W-1:0] r_fail_bits;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmp_addr  <= '0;
      r_cmp_elem  <= '0;
      r_fail_addr <= '0;
      r_fail_elem <= '0;
      r_fail_bits <= '0;
    end else begin
      r_cmp_addr <= w_addr;
      r_cmp_elem <= r_elem;
      if (w_start_ok) begin
        r_fail_addr <= '0;
        r_fail_elem <= '0;
        r_fail_bits <= '0;
      end else if (w_mis && !r_fail) begin
        // Only the first miscompare of a run is kept.
        r_fail_addr <= r_cmp_addr;
        r_fail_elem <= r_cmp_elem;
        r_fail_bits <= w_diff;
      end
    end
  end

  assign fail_addr = r_fail_addr;
  assign fail_elem = r_fail_elem;
  assign fail_bits = r_fail_bits;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_mbist_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : tb_sram_mbist_ctrl
//  Purpose : Self-checking bench for sram_mbist_ctrl (NUM_WORD=16) with a
//            behavioural SRAM offering fault modes: 0 healthy,
//            1 stuck-at-1 bit 5 at address 3, 2 writes to 5 alias into 9.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_sram_mbist_ctrl;

  localparam int NW = 16;
  localparam int AW = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] Q;
  logic          BIST, CEBM, WEBM;
  logic [AW-1:0] AM;
  logic [DW-1:0] DM, BWEBM;
  logic          bist_busy, bist_done, bist_fail;
`ifdef MBIST_DIAG_EN
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_elem;
  logic [DW-1:0] fail_bits;
`endif

  sram_mbist_ctrl #(
    .NUM_WORD (NW),
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .READ_LAT (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .Q         (Q),
    .BIST      (BIST),
    .CEBM      (CEBM),
    .WEBM      (WEBM),
    .AM        (AM),
    .DM        (DM),
    .BWEBM     (BWEBM),
    .bist_busy (bist_busy),
    .bist_done (bist_done),
    .bist_fail (bist_fail)
`ifdef MBIST_DIAG_EN
    ,
    .fail_addr (fail_addr),
    .fail_elem (fail_elem),
    .fail_bits (fail_bits)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural SRAM ----------------
  int            fault = 0;
  logic [DW-1:0] mem [NW];
  logic [DW-1:0] q_r;
  assign Q = q_r;

  initial begin
    for (int i = 0; i < NW; i++) mem[i] = '0;
    q_r = '0;
  end

  always @(posedge clk) begin
    if (CEBM == 1'b0) begin
      if (WEBM == 1'b0) begin
        mem[AM] <= (mem[AM] & BWEBM) | (DM & ~BWEBM);
        if (fault == 2 && AM == 4'd5)
          mem[9] <= (mem[9] & BWEBM) | (DM & ~BWEBM);
      end else begin
        q_r <= mem[AM] | ((fault == 1 && AM == 4'd3) ? 32'h0000_0020 : 32'h0);
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [AW-1:0] a;
    bit            wr;
    logic [DW-1:0] d;
  } op_t;

  typedef struct {
    int            k;
    bit            fail;
    logic [AW-1:0] faddr;
    logic [2:0]    felem;
    logic [DW-1:0] fbits;
  } res_t;

  op_t  op_q[$];
  res_t res_q[$];
  op_t  op_e;
  res_t res_e;
  int   vec = 0;
  int   mis = 0;
  int   ops_seen = 0;
  bit   done_d = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_elem(input bit down, input bit rd, input bit wr, input bit wpol);
    op_t o;
    for (int i = 0; i < NW; i++) begin
      o.a = down ? AW'(NW - 1 - i) : AW'(i);
      if (rd) begin
        o.wr = 1'b0; o.d = '0;
        op_q.push_back(o);
      end
      if (wr) begin
        o.wr = 1'b1; o.d = wpol ? '1 : '0;
        op_q.push_back(o);
      end
    end
  endtask

  task automatic build_march();
    push_elem(0, 0, 1, 0);   // E0 up(w0)
    push_elem(0, 1, 1, 1);   // E1 up(r0,w1)
    push_elem(0, 1, 1, 0);   // E2 up(r1,w0)
    push_elem(1, 1, 1, 1);   // E3 down(r0,w1)
    push_elem(1, 1, 1, 0);   // E4 down(r1,w0)
    push_elem(0, 1, 0, 0);   // E5 up(r0)
  endtask

  // Op monitor: every enabled SRAM cycle must match the next expected op.
  always @(negedge clk) begin
    if (rst_n && CEBM == 1'b0) begin
      ops_seen++;
      if (op_q.size() == 0) begin
        chk("unexpected_op", 64'd1, 64'd0);
      end else begin
        op_e = op_q.pop_front();
        chk("AM", AM, op_e.a);
        chk("WEBM", WEBM, !op_e.wr);
        chk("BWEBM", BWEBM, op_e.wr ? 32'h0 : 32'hFFFF_FFFF);
        if (op_e.wr) chk("DM", DM, op_e.d);
      end
    end
  end

  // Result monitor: fires on the rising edge of bist_done.
  always @(negedge clk) begin
    if (bist_done && !done_d) begin
      if (res_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        res_e = res_q.pop_front();
        chk("done_latency", cyc - res_e.k, 161);
        chk("fail_flag", bist_fail, res_e.fail);
        chk("op_count", ops_seen, 160);
        chk("ops_left", op_q.size(), 0);
`ifdef MBIST_DIAG_EN
        chk("fail_addr", fail_addr, res_e.faddr);
        chk("fail_elem", fail_elem, res_e.felem);
        chk("fail_bits", fail_bits, res_e.fbits);
`endif
      end
    end
    done_d = bist_done;
  end

  task automatic launch(input int f, input bit efail, input logic [AW-1:0] fa,
                        input logic [2:0] fe, input logic [DW-1:0] fb, output int k);
    res_t r;
    fault = f;
    @(negedge clk);
    start = 1'b1;
    ops_seen = 0;
    op_q.delete();
    build_march();
    @(posedge clk);
    #1;
    k = cyc;
    r.k = k; r.fail = efail; r.faddr = fa; r.felem = fe; r.fbits = fb;
    res_q.push_back(r);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (res_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (res_q.size() != 0) begin
      chk("done_timeout", 64'd0, 64'd1);
      res_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_idle_pins(input string tag);
    chk({tag, "_BIST"}, BIST, 1'b0);
    chk({tag, "_CEBM"}, CEBM, 1'b1);
    chk({tag, "_busy"}, bist_busy, 1'b0);
    chk({tag, "_AM"}, AM, '0);
  endtask

  initial begin
    #400_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int k;

  initial begin
    // Reset values
    #2;
    check_idle_pins("rst");
    chk("rst_WEBM", WEBM, 1'b1);
    chk("rst_DM", DM, '0);
    chk("rst_BWEBM", BWEBM, 32'hFFFF_FFFF);
    chk("rst_done", bist_done, 1'b0);
    chk("rst_fail", bist_fail, 1'b0);
`ifdef MBIST_DIAG_EN
    chk("rst_fail_bits", fail_bits, '0);
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Healthy SRAM
    launch(0, 0, '0, '0, '0, k);
    chk("run_BIST", BIST, 1'b1);
    chk("run_busy", bist_busy, 1'b1);
    wait_done();
    check_idle_pins("done");

    // Stuck-at-1, bit 5, address 3: first caught by E1 r0
    launch(1, 1, 4'h3, 3'd1, 32'h0000_0020, k);
    wait_done();
    chk("fail_sticky", bist_fail, 1'b1);
    chk("done_sticky", bist_done, 1'b1);

    // Restart from DONE with healthy SRAM: start clears fail and done
    launch(0, 0, '0, '0, '0, k);
    chk("restart_fail_clr", bist_fail, 1'b0);
    chk("restart_done_clr", bist_done, 1'b0);
    wait_done();

    // Alias 5->9: E1 w1 at 5 corrupts 9, seen by E1 r0 at 9
    launch(2, 1, 4'h9, 3'd1, 32'hFFFF_FFFF, k);
    wait_done();

    // start pulse in mid-RUN is ignored
    launch(0, 0, '0, '0, '0, k);
    while (cyc < k + 50) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("midstart_busy", bist_busy, 1'b1);
    wait_done();

    // Asynchronous reset mid-test during a failing run
    launch(1, 1, 4'h3, 3'd1, 32'h0000_0020, k);
    while (cyc < k + 70) @(negedge clk);
    chk("prerst_fail", bist_fail, 1'b1);
    rst_n = 1'b0;
    #1;
    check_idle_pins("midrst");
    chk("midrst_fail", bist_fail, 1'b0);
    chk("midrst_done", bist_done, 1'b0);
    op_q.delete();
    res_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    launch(0, 0, '0, '0, '0, k);
    wait_done();

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
`default_nettype wire
